// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: ID status and the stage enables it returns.
// id_valid is the valid and issue is the accept; an ID instruction leaves ID only in a cycle with both high.
interface hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             id_valid;
   logic [31:0]      id_ir;
   logic             ex_br_taken;
   logic             pc_en;
   logic             ir1_en;
   logic             issue;
   logic             flush_if;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt;
   logic [1:0]       dbg_state;

   modport master (
      output id_valid, id_ir, ex_br_taken,
      input  pc_en, ir1_en, issue, flush_if, halted, stall_cnt, dbg_state
   );

   modport slave (
      input  id_valid, id_ir, ex_br_taken,
      output pc_en, ir1_en, issue, flush_if, halted, stall_cnt, dbg_state
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Sequencing controller for the 5-stage core: RAW scoreboard stalls, jump/branch flushes,
// one-cycle fetch priming after reset and a drain-then-halt sequence.
module hazard_ctrl #(
   parameter int WB_LAT = 3,
   parameter int CNT_W  = 16
) (
   input logic          clk,
   input logic          rst,
   hazard_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      ST_PRIME  = 2'd0,
      ST_RUN    = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   localparam logic [1:0] LAT = 2'(WB_LAT);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [1:0]       sb_q [32];
   logic [1:0]       sb_d [32];

   logic [5:0] opcode;
   logic [4:0] rs, rt, rd, wr_addr;
   logic       use_rs, use_rt, wr_en, is_j, is_halt;
   logic       hazard, sb_late;
   logic       pc_en, ir1_en, issue, flush_if, halted, stall_inc;
   logic       unused_ir_bits;

   assign unused_ir_bits = ^bus.id_ir[10:0];

   always_comb begin
      opcode  = bus.id_ir[31:26];
      rs      = bus.id_ir[25:21];
      rt      = bus.id_ir[20:16];
      rd      = bus.id_ir[15:11];
      use_rs  = 1'b0;
      use_rt  = 1'b0;
      wr_addr = 5'd0;
      is_j    = 1'b0;
      is_halt = 1'b0;
      case (opcode)
         6'b000000: begin use_rs = 1'b1; use_rt = 1'b1; wr_addr = rd; end
         6'b001000,
         6'b100011: begin use_rs = 1'b1; wr_addr = rt; end
         6'b101011,
         6'b000100: begin use_rs = 1'b1; use_rt = 1'b1; end
         6'b000010: is_j = 1'b1;
         6'b111111: is_halt = 1'b1;
         default:   ;
      endcase
      // r0 is hardwired, so a write to it never needs a reservation
      wr_en  = (wr_addr != 5'd0);
      hazard = bus.id_valid &&
               ((use_rs && (sb_q[rs] != 2'd0)) || (use_rt && (sb_q[rt] != 2'd0)));
   end

   // Counters above 1 mean some register is still busy next cycle; drain waits on that.
   always_comb begin
      sb_late = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (sb_q[i] > 2'd1) sb_late = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_en     = 1'b0;
      ir1_en    = 1'b0;
      issue     = 1'b0;
      flush_if  = 1'b0;
      halted    = 1'b0;
      stall_inc = 1'b0;
      case (state_q)
         ST_PRIME: begin
            pc_en   = 1'b1;
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (bus.ex_br_taken) begin
               pc_en    = 1'b1;
               ir1_en   = 1'b1;
               flush_if = 1'b1;
            end else begin
               pc_en     = !hazard;
               ir1_en    = !hazard;
               issue     = bus.id_valid && !hazard;
               stall_inc = hazard;
               flush_if  = issue && is_j;
               if (issue && is_halt) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (bus.ex_br_taken) begin
               pc_en    = 1'b1;
               ir1_en   = 1'b1;
               flush_if = 1'b1;
            end
            if (!sb_late) state_d = ST_HALTED;
         end
         ST_HALTED: halted = 1'b1;
         default:   state_d = ST_PRIME;
      endcase
      if (rst) begin
         state_d   = ST_PRIME;
         pc_en     = 1'b0;
         ir1_en    = 1'b0;
         issue     = 1'b0;
         flush_if  = 1'b0;
         halted    = 1'b0;
         stall_inc = 1'b0;
      end
   end

   always_comb begin
      for (int i = 0; i < 32; i++) begin
         sb_d[i] = (sb_q[i] != 2'd0) ? sb_q[i] - 2'd1 : 2'd0;
      end
      if (issue && wr_en) sb_d[wr_addr] = LAT;
      if (rst) begin
         for (int i = 0; i < 32; i++) sb_d[i] = 2'd0;
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (stall_inc && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + 1'b1;
      if (rst) stall_d = '0;
   end

   always_ff @(posedge clk) begin
      state_q <= state_d;
      stall_q <= stall_d;
      for (int i = 0; i < 32; i++) sb_q[i] <= sb_d[i];
   end

   assign bus.pc_en     = pc_en;
   assign bus.ir1_en    = ir1_en;
   assign bus.issue     = issue;
   assign bus.flush_if  = flush_if;
   assign bus.halted    = halted;
   assign bus.stall_cnt = rst ? '0 : stall_q;
   assign bus.dbg_state = state_q;
endmodule
